// File: rtl/cla_seq_accumulator_pkg.sv
// Shared constants for the sequential carry-lookahead accumulator.
//   - FSM state encodings (3 bits, legacy-compatible localparams)
//   - clog2_f: elaboration-time ceiling log2 used to size op_count
package cla_seq_accumulator_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_WAIT_OP = 3'd2;
  localparam logic [2:0] S_ADD     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_seq_accumulator_cla_adder.sv
// Blocked carry-lookahead adder (purely combinational).
//   a, b  : WIDTH-bit addends
//   cin   : carry into bit 0
//   s     : WIDTH-bit sum (mod 2^WIDTH)
//   cout  : carry out of the MSB
// Bits are grouped CLA_BLOCK at a time. Each group produces a group
// generate/propagate; group carries are formed in sum-of-products
// lookahead form from those, and bits inside a group take their carry
// from the group carry-in.
module cla_adder
  import cla_seq_accumulator_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLA_BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = WIDTH / CLA_BLOCK;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic             t;
  logic             cb;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    s  = '0;
    t  = 1'b0;
    cb = 1'b0;

    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int i = 0; i < CLA_BLOCK; i++) begin
        gg[k] = g[k*CLA_BLOCK+i] | (p[k*CLA_BLOCK+i] & gg[k]);
        gp[k] = gp[k] & p[k*CLA_BLOCK+i];
      end
    end

    // Group carry k+1 = OR over j<=k of (gg[j] & gp[j+1..k]) | (cin & gp[0..k])
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      t = cin;
      for (int m = 0; m <= k; m++) t = t & gp[m];
      gc[k+1] = t;
      for (int j = 0; j <= k; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= k; m++) t = t & gp[m];
        gc[k+1] = gc[k+1] | t;
      end
    end

    for (int k = 0; k < NG; k++) begin
      cb = gc[k];
      for (int i = 0; i < CLA_BLOCK; i++) begin
        s[k*CLA_BLOCK+i] = p[k*CLA_BLOCK+i] ^ cb;
        cb = g[k*CLA_BLOCK+i] | (p[k*CLA_BLOCK+i] & cb);
      end
    end

    cout = gc[NG];
  end

endmodule

// File: rtl/cla_seq_accumulator.sv
// Sequential accumulator: sums NUM_OPS operands taken one per valid/ready
// transfer, each added or subtracted through a blocked CLA adder.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (only honoured in IDLE)
//   in_valid   : operand present on in_data / in_sub
//   in_data    : operand value
//   in_sub     : 1 = subtract operand, 0 = add
//   in_ready   : operand accepted this cycle when in_valid is also high
//   busy       : run in progress (CLEAR, WAIT_OP, ADD)
//   done       : one-cycle pulse, sum/carry_err are final
//   sum        : accumulator (mod 2^WIDTH)
//   carry_err  : sticky, any add carried out or any subtract borrowed
//   op_count   : operands accumulated so far in this run
module cla_seq_accumulator
  import cla_seq_accumulator_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_OPS   = 4,
  parameter int CLA_BLOCK = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               in_valid,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_sub,
  output logic                               in_ready,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH-1:0]                   sum,
  output logic                               carry_err,
  output logic [clog2_f(NUM_OPS+1)-1:0]      op_count
);

  localparam int CNT_W = clog2_f(NUM_OPS + 1);
  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_s;
  logic             add_co;

  // Subtract is acc + ~b + 1: invert the operand and feed sub_reg as carry-in.
  assign b_eff = sub_reg ? ~b_reg : b_reg;

  cla_adder #(
    .WIDTH    (WIDTH),
    .CLA_BLOCK(CLA_BLOCK)
  ) u_cla_adder (
    .a   (sum),
    .b   (b_eff),
    .cin (sub_reg),
    .s   (add_s),
    .cout(add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sum       <= '0;
      carry_err <= 1'b0;
      op_count  <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          sum       <= '0;
          op_count  <= '0;
          carry_err <= 1'b0;
          state     <= S_WAIT_OP;
        end
        S_WAIT_OP: begin
          if (in_valid) begin
            b_reg   <= in_data;
            sub_reg <= in_sub;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          sum       <= add_s;
          // Add flags a carry out; subtract flags a borrow (no carry out).
          carry_err <= carry_err | (add_co ^ sub_reg);
          op_count  <= op_count + CNT_W'(1);
          state     <= (op_count == LAST_OP) ? S_DONE : S_WAIT_OP;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready = (state == S_WAIT_OP);
    busy     = (state == S_CLEAR) || (state == S_WAIT_OP) || (state == S_ADD);
    done     = (state == S_DONE);
  end

endmodule

// File: tb/tb_cla_seq_accumulator.sv
module tb_cla_seq_accumulator;

  logic clk;
  logic rst;

  // Default-parameter instance (16-bit, 4 ops, 4-bit blocks)
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sub;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_err;
  logic [2:0]  op_count;

  // Wide instance (32-bit, 3 ops, 8-bit blocks)
  logic        start_w;
  logic        in_valid_w;
  logic [31:0] in_data_w;
  logic        in_sub_w;
  logic        in_ready_w;
  logic        busy_w;
  logic        done_w;
  logic [31:0] sum_w;
  logic        carry_err_w;
  logic [1:0]  op_count_w;

  int tests_run;
  int tests_failed;

  logic [15:0] op_d[4];
  logic        op_s[4];
  logic [31:0] op_dw[3];
  int          cyc;

  cla_seq_accumulator u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_err(carry_err),
    .op_count (op_count)
  );

  cla_seq_accumulator #(
    .WIDTH    (32),
    .NUM_OPS  (3),
    .CLA_BLOCK(8)
  ) u_dut_w (
    .clk      (clk),
    .rst      (rst),
    .start    (start_w),
    .in_valid (in_valid_w),
    .in_data  (in_data_w),
    .in_sub   (in_sub_w),
    .in_ready (in_ready_w),
    .busy     (busy_w),
    .done     (done_w),
    .sum      (sum_w),
    .carry_err(carry_err_w),
    .op_count (op_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run on the 16-bit instance. gap = extra WAIT_OP cycles with
  // in_valid low before each operand. abort_after > 0 asserts rst right after
  // that many transfers and returns. cyc_out = edges after the start edge at
  // which done is first observed high.
  task automatic run16(input int gap, input bit mid_start, input int abort_after,
                       output int cyc_out);
    int n;
    cyc_out = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clear_busy", 32'(busy), 32'd1);
    check("clear_rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        cyc_out++;
        n++;
      end
      if (n >= 50) begin
        check("rdy_timeout", 32'd0, 32'd1);
        return;
      end
      for (int g = 0; g < gap; g++) begin
        if (mid_start && g == 1) start = 1'b1;
        tick();
        cyc_out++;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = op_d[i];
      in_sub   = op_s[i];
      tick();
      cyc_out++;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      in_sub   = 1'b1;
      check("add_rdy_low", 32'(in_ready), 32'd0);
      if (abort_after == i + 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
    end
    tick();
    cyc_out++;
    check("done_hi", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run32(output int cyc_out);
    int n;
    cyc_out = 0;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready_w && n < 50) begin
        tick();
        cyc_out++;
        n++;
      end
      if (n >= 50) begin
        check("w_rdy_timeout", 32'd0, 32'd1);
        return;
      end
      in_valid_w = 1'b1;
      in_data_w  = op_dw[i];
      in_sub_w   = 1'b0;
      tick();
      cyc_out++;
      in_valid_w = 1'b0;
    end
    tick();
    cyc_out++;
    check("w_done_hi", 32'(done_w), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sub     = 1'b0;
    start_w    = 1'b0;
    in_valid_w = 1'b0;
    in_data_w  = '0;
    in_sub_w   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_sum", 32'(sum), 32'h0);
    check("rst_err", 32'(carry_err), 32'd0);
    check("rst_cnt", 32'(op_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 1 + 2 + 3 + 4
    op_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    op_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    run16(0, 1'b0, 0, cyc);
    check("t1_latency", 32'(cyc), 32'd9);
    check("t1_sum", 32'(sum), 32'h000A);
    check("t1_err", 32'(carry_err), 32'd0);
    check("t1_cnt", 32'(op_count), 32'd4);

    // Carry out of 0xFFFF + 1 stays sticky through later zero adds
    op_d = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
    op_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    run16(0, 1'b0, 0, cyc);
    check("t2_sum", 32'(sum), 32'h0000);
    check("t2_err", 32'(carry_err), 32'd1);

    // 0x10 - 3 - 1 + 0, no borrow
    op_d = '{16'h0010, 16'h0003, 16'h0001, 16'h0000};
    op_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    run16(0, 1'b0, 0, cyc);
    check("t3_sum", 32'(sum), 32'h000C);
    check("t3_err", 32'(carry_err), 32'd0);

    // Leading subtract wraps negative and borrows
    op_d = '{16'h0005, 16'h0000, 16'h0000, 16'h0000};
    op_s = '{1'b1, 1'b0, 1'b0, 1'b0};
    run16(0, 1'b0, 0, cyc);
    check("t3b_sum", 32'(sum), 32'hFFFB);
    check("t3b_err", 32'(carry_err), 32'd1);
    tick();
    check("t3b_hold_sum", 32'(sum), 32'hFFFB);
    check("t3b_hold_cnt", 32'(op_count), 32'd4);

    // Producer gaps of 3 cycles per operand plus a mid-run start pulse
    op_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    op_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    run16(3, 1'b1, 0, cyc);
    check("t4_latency", 32'(cyc), 32'd21);
    check("t4_sum", 32'(sum), 32'h000A);
    check("t4_err", 32'(carry_err), 32'd0);
    tick();
    check("t4_no_rerun", 32'(busy), 32'd0);

    // Reset after the 2nd operand aborts the run
    op_d = '{16'h0005, 16'h0007, 16'h0000, 16'h0000};
    op_s = '{1'b1, 1'b0, 1'b0, 1'b0};
    run16(0, 1'b0, 2, cyc);
    check("t5_sum", 32'(sum), 32'h0);
    check("t5_err", 32'(carry_err), 32'd0);
    check("t5_cnt", 32'(op_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rdy", 32'(in_ready), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    tick();
    check("t5_done_after", 32'(done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    op_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    op_s = '{1'b0, 1'b0, 1'b0, 1'b0};
    run16(0, 1'b0, 0, cyc);
    check("t5_fresh_sum", 32'(sum), 32'h000A);
    check("t5_fresh_lat", 32'(cyc), 32'd9);

    // Wide instance: 0x7FFFFFFF + 1 + 0x80000000 carries out
    op_dw = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    run32(cyc);
    check("t6_latency", 32'(cyc), 32'd7);
    check("t6_sum", sum_w, 32'h0000_0000);
    check("t6_err", 32'(carry_err_w), 32'd1);
    check("t6_cnt", 32'(op_count_w), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
